// File: rtl/skill_manager.sv
// Skill bookkeeping stage for the ball controller and board-movement logic.
// Edge-detects the J/K/L skill keys, arbitrates one accept per tick (J > K > L),
// spends and regenerates skill points, and runs one duration timer per skill.
module skill_manager #(
    parameter int unsigned MAX_POINTS  = 3,
    parameter int unsigned REGEN_TICKS = 200,
    parameter int unsigned DUR0        = 100,
    parameter int unsigned DUR1        = 100,
    parameter int unsigned DUR2        = 60,
    parameter int unsigned SLOW_VX     = 10,
    parameter int unsigned FAST_VX     = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [2:0] req,
    output logic [2:0] grant,
    output logic [2:0] active,
    output logic [1:0] skill_point,
    output logic [9:0] board_vx
);

    localparam logic [1:0]  MaxPts    = 2'(MAX_POINTS);
    localparam logic [7:0]  RegenLast = 8'(REGEN_TICKS - 1);
    localparam logic [23:0] DurVec    = {8'(DUR2), 8'(DUR1), 8'(DUR0)};
    localparam logic [9:0]  SlowVx    = 10'(SLOW_VX);
    localparam logic [9:0]  FastVx    = 10'(FAST_VX);

    logic [2:0]      req_q;
    logic [2:0]      grant_q, grant_d;
    logic [2:0]      active_q, active_d;
    logic [2:0][7:0] timer_q, timer_d;
    logic [7:0]      regen_q, regen_d;
    logic [1:0]      point_q, point_d;

    logic [2:0] rise;
    logic [2:0] cand;
    logic [2:0] sel;
    logic       accept;
    logic       wrap;

    // Rising-edge detect and fixed-priority pick of at most one skill.
    always_comb begin
        rise = req & ~req_q;
        cand = rise & ~active_q & {3{en && (point_q != 2'd0)}};
        sel  = 3'b000;
        if (cand[0]) begin
            sel = 3'b001;
        end else if (cand[1]) begin
            sel = 3'b010;
        end else if (cand[2]) begin
            sel = 3'b100;
        end
        accept  = |sel;
        grant_d = sel;
    end

    // Regen counter: runs only while enabled, wraps every REGEN_TICKS ticks.
    always_comb begin
        regen_d = 8'd0;
        wrap    = 1'b0;
        if (en) begin
            if (regen_q == RegenLast) begin
                wrap = 1'b1;
            end else begin
                regen_d = regen_q + 8'd1;
            end
        end
    end

    // Point bookkeeping; a spend and a regen on the same tick cancel out.
    always_comb begin
        point_d = point_q;
        if (accept && !wrap) begin
            point_d = point_q - 2'd1;
        end else if (wrap && !accept && (point_q < MaxPts)) begin
            point_d = point_q + 2'd1;
        end
    end

    // Per-skill duration timers; the timer reaching 1 ends the active window.
    always_comb begin
        timer_d  = timer_q;
        active_d = active_q;
        for (int i = 0; i < 3; i++) begin
            if (!en) begin
                timer_d[i]  = 8'd0;
                active_d[i] = 1'b0;
            end else if (sel[i]) begin
                timer_d[i]  = DurVec[8*i +: 8];
                active_d[i] = 1'b1;
            end else if (active_q[i]) begin
                if (timer_q[i] == 8'd1) begin
                    timer_d[i]  = 8'd0;
                    active_d[i] = 1'b0;
                end else begin
                    timer_d[i] = timer_q[i] - 8'd1;
                end
            end
        end
    end

    // Output mapping; board speed follows the registered skill-1 active bit.
    always_comb begin
        grant       = grant_q;
        active      = active_q;
        skill_point = point_q;
        board_vx    = active_q[1] ? FastVx : SlowVx;
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            req_q    <= 3'b000;
            grant_q  <= 3'b000;
            active_q <= 3'b000;
            timer_q  <= '0;
            regen_q  <= 8'd0;
            point_q  <= 2'd0;
        end else begin
            req_q    <= req;
            grant_q  <= grant_d;
            active_q <= active_d;
            timer_q  <= timer_d;
            regen_q  <= regen_d;
            point_q  <= point_d;
        end
    end

endmodule

// File: tb/tb_skill_manager.sv
// Testbench for skill_manager: directed stimulus with a grant scoreboard.
module tb_skill_manager;

    logic       clk;
    logic       rst;
    logic       en;
    logic [2:0] req;
    logic [2:0] grant;
    logic [2:0] active;
    logic [1:0] skill_point;
    logic [9:0] board_vx;

    typedef struct packed {
        logic [2:0] g;
        logic [1:0] p;
        logic [2:0] a;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   edge_n  = 0;

    skill_manager dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .req         (req),
        .grant       (grant),
        .active      (active),
        .skill_point (skill_point),
        .board_vx    (board_vx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int expv);
        n_tests++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, expv, edge_n);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        edge_n++;
        #1;
    endtask

    task automatic run_to(input int n);
        while (edge_n < n) tick();
    endtask

    task automatic expect_grant(input logic [2:0] g, input logic [1:0] p, input logic [2:0] a);
        exp_t e;
        e.g = g;
        e.p = p;
        e.a = a;
        exp_q.push_back(e);
    endtask

    // Monitor: every nonzero grant must match the next scoreboard entry.
    always @(negedge clk) begin
        if (grant != 3'b000) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_grant: got %b, expected none (edge %0d)", grant, edge_n);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_grant", int'(grant), int'(e.g));
                check("sb_points", int'(skill_point), int'(e.p));
                check("sb_active", int'(active), int'(e.a));
            end
        end
    end

    initial begin
        int hi_cnt;
        rst = 1'b0;
        en  = 1'b0;
        req = 3'b000;
        repeat (3) tick();
        check("rst_grant", int'(grant), 0);
        check("rst_active", int'(active), 0);
        check("rst_points", int'(skill_point), 0);
        check("rst_vx", int'(board_vx), 10);

        // Regen and saturation.
        rst    = 1'b1;
        en     = 1'b1;
        edge_n = 0;
        run_to(199); check("regen_199", int'(skill_point), 0);
        run_to(200); check("regen_200", int'(skill_point), 1);
        run_to(400); check("regen_400", int'(skill_point), 2);
        run_to(600); check("regen_600", int'(skill_point), 3);
        run_to(800); check("regen_800", int'(skill_point), 3);

        // Single use of skill 1, key held 5 cycles.
        req = 3'b010;
        expect_grant(3'b010, 2'd2, 3'b010);
        hi_cnt = 0;
        for (int i = 1; i <= 110; i++) begin
            tick();
            if (i == 5) req = 3'b000;
            if (active[1]) hi_cnt++;
            if (i == 2) check("single_grant_off", int'(grant), 0);
            if (i == 50) check("single_vx_fast", int'(board_vx), 20);
            if (i == 101) check("single_vx_slow", int'(board_vx), 10);
        end
        check("single_active_len", hi_cnt, 100);
        check("single_points", int'(skill_point), 2);

        // Arbitration at full points; then re-press of active J is rejected.
        run_to(1000);
        check("arb_pre_points", int'(skill_point), 3);
        req = 3'b111;
        expect_grant(3'b001, 2'd2, 3'b001);
        tick();
        check("arb_active", int'(active), 1);
        check("arb_points", int'(skill_point), 2);
        req = 3'b000;
        tick();
        req = 3'b001;
        tick();
        req = 3'b000;
        check("repress_points", int'(skill_point), 2);
        check("repress_active", int'(active), 1);
        run_to(1100);
        check("timer_kept_hi", int'(active[0]), 1);
        tick();
        check("timer_kept_lo", int'(active[0]), 0);

        // Spend down to zero, then L with no points is rejected.
        req = 3'b001;
        expect_grant(3'b001, 2'd1, 3'b001);
        tick();
        req = 3'b000;
        tick();
        req = 3'b010;
        expect_grant(3'b010, 2'd0, 3'b011);
        tick();
        req = 3'b000;
        tick();
        req = 3'b100;
        tick();
        req = 3'b000;
        check("nopts_active", int'(active), 3);
        check("nopts_points", int'(skill_point), 0);

        // J rise on a regen wrap at full points.
        run_to(1799);
        check("wrap_pre_points", int'(skill_point), 3);
        req = 3'b001;
        expect_grant(3'b001, 2'd3, 3'b001);
        tick();
        req = 3'b000;
        check("wrap_points", int'(skill_point), 3);
        check("wrap_active", int'(active), 1);
        repeat (5) tick();

        // Drop en mid-skill.
        en = 1'b0;
        tick();
        check("dis_active", int'(active), 0);
        check("dis_points", int'(skill_point), 3);

        // J held through en rising gives no grant.
        req = 3'b001;
        repeat (2) tick();
        en     = 1'b1;
        edge_n = 0;
        repeat (3) tick();
        check("held_active", int'(active), 0);
        check("held_points", int'(skill_point), 3);
        req = 3'b000;
        tick();

        // Reset mid-skill.
        req = 3'b010;
        expect_grant(3'b010, 2'd2, 3'b010);
        tick();
        req = 3'b000;
        repeat (3) tick();
        check("mid_active", int'(active), 2);
        check("mid_vx", int'(board_vx), 20);
        rst = 1'b0;
        tick();
        check("mrst_grant", int'(grant), 0);
        check("mrst_active", int'(active), 0);
        check("mrst_points", int'(skill_point), 0);
        check("mrst_vx", int'(board_vx), 10);
        rst = 1'b1;
        repeat (3) tick();

        check("sb_leftover", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
